// File: rtl/dispatch_2_service.sv
// Dispatches one valid/ready stream onto two buffered consumer ports, routing by
// the beat's top bit or by strict round-robin; each port keeps a delivered-beat count.

module dispatch_2_service_port #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              out_ready,
    output logic              full,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [CNT_W-1:0]  cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    logic              pop;

    assign full      = (occ == FULL_OCC);
    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;
    // Head is forced to zero when empty so reset and idle present a clean bus.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module dispatch_2_service #(
    parameter int DWIDTH  = 8,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data_0,
    output logic              out_valid_0,
    input  logic              out_ready_0,
    output logic [DWIDTH-1:0] out_data_1,
    output logic              out_valid_1,
    input  logic              out_ready_1,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1
);
    logic                   run;
    logic                   rr_ptr;
    logic                   tgt;
    logic                   accept;
    logic [1:0]             full, push, valid, ready;
    logic [1:0][DWIDTH-1:0] data;
    logic [1:0][CNT_W-1:0]  cnt;

    // in_ready looks only at registered FIFO state, so a same-cycle pop never frees a slot.
    assign tgt      = (RR_MODE != 0) ? rr_ptr : in_data[DWIDTH-1];
    assign in_ready = run & ~full[tgt];
    assign accept   = in_valid & in_ready;
    assign push[0]  = accept & ~tgt;
    assign push[1]  = accept & tgt;
    assign ready    = {out_ready_1, out_ready_0};

    // run holds in_ready low through reset and releases on the first edge after it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            run    <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) rr_ptr <= ~rr_ptr;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_port
        dispatch_2_service_port #(
            .DWIDTH(DWIDTH),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_port (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .push     (push[k]),
            .push_data(in_data),
            .out_ready(ready[k]),
            .full     (full[k]),
            .out_valid(valid[k]),
            .out_data (data[k]),
            .cnt      (cnt[k])
        );
    end

    assign out_data_0  = data[0];
    assign out_valid_0 = valid[0];
    assign cnt_0       = cnt[0];
    assign out_data_1  = data[1];
    assign out_valid_1 = valid[1];
    assign cnt_1       = cnt[1];
endmodule
